bp_axi_dma_gearbox: RTL and testbench

// - Multi-channel bidirectional width converter between L2 DMA fill words (wide) and AXI4 data beats (narrow).
// - Replaces per-channel SIPO/PISO pairs between bp_processor DMA ports and bsg_cache_to_axi.
// - Generalised in channel count and ratio; zero-bubble streaming; emits a last flag per wide word on the write path.

---
 rtl/bp_axi_dma_gearbox.sv | 174 +++++++++++++++++
 tb/tb_bp_axi_dma_gearbox.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_axi_dma_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : bp_axi_dma_gearbox
// Description : Multi-channel bidirectional width converter between wide L2
//               DMA fill words and narrow AXI4 data beats. Read path packs
//               narrow beats into a wide word (lowest slice first); write path
//               unpacks a wide word into narrow beats with a last flag.
//               Zero-bubble streaming in both directions, channels independent.
//               Optional per-channel transfer counters are enabled by defining
//               BP_AXI_DMA_GEARBOX_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_axi_dma_gearbox #(
    parameter int num_channels_p = 1,
    parameter int wide_width_p   = 512,
    parameter int narrow_width_p = 64
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,

    input  logic [num_channels_p-1:0][narrow_width_p-1:0] rd_narrow_data_i,
    input  logic [num_channels_p-1:0]                     rd_narrow_v_i,
    output logic [num_channels_p-1:0]                     rd_narrow_ready_and_o,
    output logic [num_channels_p-1:0][wide_width_p-1:0]   rd_wide_data_o,
    output logic [num_channels_p-1:0]                     rd_wide_v_o,
    input  logic [num_channels_p-1:0]                     rd_wide_ready_and_i,

    input  logic [num_channels_p-1:0][wide_width_p-1:0]   wr_wide_data_i,
    input  logic [num_channels_p-1:0]                     wr_wide_v_i,
    output logic [num_channels_p-1:0]                     wr_wide_ready_and_o,
    output logic [num_channels_p-1:0][narrow_width_p-1:0] wr_narrow_data_o,
    output logic [num_channels_p-1:0]                     wr_narrow_v_o,
    output logic [num_channels_p-1:0]                     wr_narrow_last_o,
    input  logic [num_channels_p-1:0]                     wr_narrow_ready_and_i
`ifdef BP_AXI_DMA_GEARBOX_COUNTERS_EN
   ,output logic [num_channels_p-1:0][31:0]               rd_words_o
   ,output logic [num_channels_p-1:0][31:0]               wr_words_o
`endif
);

    localparam int c_ratio = wide_width_p / narrow_width_p;
    localparam int c_cnt_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ratio - 1);

    // Reject geometries the slice indexing cannot represent
    generate
        if ((wide_width_p % narrow_width_p) != 0 || c_ratio < 1 ||
            (c_ratio & (c_ratio - 1)) != 0) begin : g_param_check
            $error("bp_axi_dma_gearbox: wide/narrow must be a power-of-2 integer ratio");
        end
    endgenerate

    generate
        for (genvar g = 0; g < num_channels_p; g++) begin : g_chan
            // ---------------- read path: narrow beats -> wide word ----------
            logic [wide_width_p-1:0] r_rd_asm;
            logic [wide_width_p-1:0] r_rd_word;
            logic [wide_width_p-1:0] w_rd_asm_next;
            logic [c_cnt_w-1:0]      r_rd_cnt;
            logic                    r_rd_v;
            logic                    w_rd_ready;
            logic                    w_rd_accept;

            // A held word blocks new beats unless it drains this same cycle
            assign w_rd_ready  = ~r_rd_v | rd_wide_ready_and_i[g];
            assign w_rd_accept = rd_narrow_v_i[g] & w_rd_ready;

            // Assembly buffer with the incoming beat dropped into its slice
            always_comb begin
                w_rd_asm_next = r_rd_asm;
                w_rd_asm_next[r_rd_cnt*narrow_width_p +: narrow_width_p] = rd_narrow_data_i[g];
            end

            // Assembly lives apart from the output word so partial data never shows
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_rd_asm  <= '0;
                    r_rd_word <= '0;
                    r_rd_cnt  <= '0;
                    r_rd_v    <= 1'b0;
                end else begin
                    if (r_rd_v && rd_wide_ready_and_i[g]) begin
                        r_rd_v <= 1'b0;
                    end
                    if (w_rd_accept) begin
                        if (r_rd_cnt == c_last) begin
                            r_rd_word <= w_rd_asm_next;
                            r_rd_v    <= 1'b1;
                            r_rd_cnt  <= '0;
                        end else begin
                            r_rd_asm  <= w_rd_asm_next;
                            r_rd_cnt  <= r_rd_cnt + 1'b1;
                        end
                    end
                end
            end

            assign rd_narrow_ready_and_o[g] = w_rd_ready;
            assign rd_wide_data_o[g]        = r_rd_word;
            assign rd_wide_v_o[g]           = r_rd_v;

            // ---------------- write path: wide word -> narrow beats ---------
            logic [wide_width_p-1:0] r_wr_buf;
            logic [c_cnt_w-1:0]      r_wr_cnt;
            logic                    r_wr_v;
            logic                    w_wr_beat_done;
            logic                    w_wr_end;
            logic                    w_wr_ready;
            logic                    w_wr_capture;

            assign w_wr_beat_done = r_wr_v & wr_narrow_ready_and_i[g];
            assign w_wr_end       = w_wr_beat_done & (r_wr_cnt == c_last);
            assign w_wr_ready     = ~r_wr_v | w_wr_end;
            assign w_wr_capture   = wr_wide_v_i[g] & w_wr_ready;

            // Shift register presents slice 0 first; a new word may load on the last beat
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_wr_buf <= '0;
                    r_wr_cnt <= '0;
                    r_wr_v   <= 1'b0;
                end else if (w_wr_capture) begin
                    r_wr_buf <= wr_wide_data_i[g];
                    r_wr_cnt <= '0;
                    r_wr_v   <= 1'b1;
                end else if (w_wr_end) begin
                    r_wr_buf <= r_wr_buf >> narrow_width_p;
                    r_wr_cnt <= '0;
                    r_wr_v   <= 1'b0;
                end else if (w_wr_beat_done) begin
                    r_wr_buf <= r_wr_buf >> narrow_width_p;
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            assign wr_wide_ready_and_o[g] = w_wr_ready;
            assign wr_narrow_data_o[g]    = r_wr_buf[narrow_width_p-1:0];
            assign wr_narrow_v_o[g]       = r_wr_v;
            assign wr_narrow_last_o[g]    = r_wr_v & (r_wr_cnt == c_last);

`ifdef BP_AXI_DMA_GEARBOX_COUNTERS_EN
            logic [31:0] r_rd_words;
            logic [31:0] r_wr_words;

            // Count completed wide-side handshakes; natural 32-bit wrap
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    r_rd_words <= '0;
                    r_wr_words <= '0;
                end else begin
                    if (r_rd_v && rd_wide_ready_and_i[g]) begin
                        r_rd_words <= r_rd_words + 32'd1;
                    end
                    if (w_wr_capture) begin
                        r_wr_words <= r_wr_words + 32'd1;
                    end
                end
            end

            assign rd_words_o[g] = r_rd_words;
            assign wr_words_o[g] = r_wr_words;
`endif

`ifndef SYNTHESIS
            a_rd_hold : assert property (@(posedge clk_i) disable iff (reset_i)
                (r_rd_v && !rd_wide_ready_and_i[g]) |=> (r_rd_v && $stable(r_rd_word)));
            a_wr_hold : assert property (@(posedge clk_i) disable iff (reset_i)
                (r_wr_v && !wr_narrow_ready_and_i[g]) |=> (r_wr_v && $stable(r_wr_buf[narrow_width_p-1:0])));
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bp_axi_dma_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_axi_dma_gearbox
// Description : Scoreboard bench for bp_axi_dma_gearbox, 2 channels, 128/32.
//               Counter checks are compiled when BP_AXI_DMA_GEARBOX_COUNTERS_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_axi_dma_gearbox;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [1:0][31:0]  rd_narrow_data;
    logic [1:0]        rd_narrow_v;
    logic [1:0]        rd_narrow_ready;
    logic [1:0][127:0] rd_wide_data;
    logic [1:0]        rd_wide_v;
    logic [1:0]        rd_wide_ready;
    logic [1:0][127:0] wr_wide_data;
    logic [1:0]        wr_wide_v;
    logic [1:0]        wr_wide_ready;
    logic [1:0][31:0]  wr_narrow_data;
    logic [1:0]        wr_narrow_v;
    logic [1:0]        wr_narrow_last;
    logic [1:0]        wr_narrow_ready;
`ifdef BP_AXI_DMA_GEARBOX_COUNTERS_EN
    logic [1:0][31:0]  rd_words;
    logic [1:0][31:0]  wr_words;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] rd_q0[$];
    logic [127:0] rd_q1[$];
    logic [32:0]  wr_q0[$];
    logic [32:0]  wr_q1[$];

    bp_axi_dma_gearbox #(
        .num_channels_p(2), .wide_width_p(128), .narrow_width_p(32)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .rd_narrow_data_i(rd_narrow_data), .rd_narrow_v_i(rd_narrow_v),
        .rd_narrow_ready_and_o(rd_narrow_ready),
        .rd_wide_data_o(rd_wide_data), .rd_wide_v_o(rd_wide_v),
        .rd_wide_ready_and_i(rd_wide_ready),
        .wr_wide_data_i(wr_wide_data), .wr_wide_v_i(wr_wide_v),
        .wr_wide_ready_and_o(wr_wide_ready),
        .wr_narrow_data_o(wr_narrow_data), .wr_narrow_v_o(wr_narrow_v),
        .wr_narrow_last_o(wr_narrow_last),
        .wr_narrow_ready_and_i(wr_narrow_ready)
`ifdef BP_AXI_DMA_GEARBOX_COUNTERS_EN
       ,.rd_words_o(rd_words), .wr_words_o(wr_words)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int ch, input logic [127:0] w);
        for (int i = 0; i < 4; i++) begin
            if (ch == 0) wr_q0.push_back({(i == 3), w[i*32 +: 32]});
            else         wr_q1.push_back({(i == 3), w[i*32 +: 32]});
        end
    endtask

    // Present one read beat and hold it until the DUT accepts it
    task automatic rd_beat(input int ch, input logic [31:0] d);
        bit ok;
        int n;
        n = 0;
        rd_narrow_v[ch]    = 1'b1;
        rd_narrow_data[ch] = d;
        do begin
            @(negedge clk);
            ok = rd_narrow_ready[ch];
            step();
            n++;
        end while (!ok && n < 200);
        chk("rd_beat_accept", ok, 1);
    endtask

    task automatic rd_word(input int ch, input logic [127:0] w);
        if (ch == 0) rd_q0.push_back(w);
        else         rd_q1.push_back(w);
        for (int i = 0; i < 4; i++) rd_beat(ch, w[i*32 +: 32]);
        rd_narrow_v[ch] = 1'b0;
    endtask

    task automatic wr_word(input int ch, input logic [127:0] w);
        bit ok;
        int n;
        n = 0;
        push_wr(ch, w);
        wr_wide_v[ch]    = 1'b1;
        wr_wide_data[ch] = w;
        do begin
            @(negedge clk);
            ok = wr_wide_ready[ch];
            step();
            n++;
        end while (!ok && n < 200);
        chk("wr_word_accept", ok, 1);
        wr_wide_v[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q0.size() + rd_q1.size() + wr_q0.size() + wr_q1.size()) != 0 && n < 100) begin
            step();
            n++;
        end
        chk("scoreboard_empty", rd_q0.size() + rd_q1.size() + wr_q0.size() + wr_q1.size(), 0);
    endtask

    // Output monitor: scoreboard on handshakes, stability while stalled
    logic [1:0]       prev_stall = '0;
    logic [1:0][31:0] prev_data;
    always @(negedge clk) begin
        logic [127:0] exp_w;
        logic [32:0]  exp_b;
        if (reset_i) begin
            prev_stall = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (rd_wide_v[c] && rd_wide_ready[c]) begin
                    if ((c == 0 && rd_q0.size() == 0) || (c == 1 && rd_q1.size() == 0)) begin
                        chk("rd_unexpected_word", rd_wide_v[c], 0);
                    end else begin
                        if (c == 0) exp_w = rd_q0.pop_front();
                        else        exp_w = rd_q1.pop_front();
                        chk("rd_word", rd_wide_data[c], exp_w);
                    end
                end
                if (wr_narrow_v[c] && wr_narrow_ready[c]) begin
                    if ((c == 0 && wr_q0.size() == 0) || (c == 1 && wr_q1.size() == 0)) begin
                        chk("wr_unexpected_beat", wr_narrow_v[c], 0);
                    end else begin
                        if (c == 0) exp_b = wr_q0.pop_front();
                        else        exp_b = wr_q1.pop_front();
                        chk("wr_beat_data", wr_narrow_data[c], exp_b[31:0]);
                        chk("wr_beat_last", wr_narrow_last[c], exp_b[32]);
                    end
                end
                if (!wr_narrow_v[c]) chk("wr_last_idle", wr_narrow_last[c], 0);
                if (prev_stall[c]) begin
                    chk("wr_stall_valid", wr_narrow_v[c], 1);
                    chk("wr_stall_data", wr_narrow_data[c], prev_data[c]);
                end
                prev_stall[c] = wr_narrow_v[c] & ~wr_narrow_ready[c];
                prev_data[c]  = wr_narrow_data[c];
            end
        end
    end

    localparam logic [127:0] c_w1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] c_w2 = 128'h0F0F0F0F_E1E1E1E1_D2D2D2D2_C3C3C3C3;

    initial begin
        reset_i         = 1'b1;
        rd_narrow_data  = '0;
        rd_narrow_v     = 2'b01;
        rd_narrow_data[0] = 32'h11111111;
        rd_wide_ready   = 2'b11;
        wr_wide_data    = '0;
        wr_wide_v       = '0;
        wr_narrow_ready = 2'b11;
        rd_q0.push_back(128'h44444444_33333333_22222222_11111111);

        // Reset state with a read beat already offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_wide_v", rd_wide_v, 2'b00);
        chk("reset_wr_narrow_v", wr_narrow_v, 2'b00);
        chk("reset_rd_ready", rd_narrow_ready, 2'b11);
        chk("reset_wr_ready", wr_wide_ready, 2'b11);
        chk("reset_rd_data", rd_wide_data[0], 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("first_beat_ready", rd_narrow_ready[0], 1);
        step();
        rd_beat(0, 32'h22222222);
        rd_beat(0, 32'h33333333);
        rd_beat(0, 32'h44444444);

        // Word visible one cycle after the fourth beat; next beat accepted alongside
        rd_q0.push_back(128'h88888888_77777777_66666666_55555555);
        rd_narrow_data[0] = 32'h55555555;
        @(negedge clk);
        chk("rd_valid_after_beat4", rd_wide_v[0], 1);
        chk("rd_data_after_beat4", rd_wide_data[0], 128'h44444444_33333333_22222222_11111111);
        chk("rd_ready_while_drain", rd_narrow_ready[0], 1);
        step();
        rd_beat(0, 32'h66666666);
        rd_beat(0, 32'h77777777);
        rd_beat(0, 32'h88888888);
        rd_narrow_v[0] = 1'b0;
        step();

        // Write with toggling beat ready and a second word on the last handshake
        push_wr(0, c_w1);
        wr_wide_v[0]    = 1'b1;
        wr_wide_data[0] = c_w1;
        @(negedge clk);
        chk("wr_ready_idle", wr_wide_ready[0], 1);
        step();
        wr_wide_v[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_narrow_ready[0] = (k % 2 == 0);
            @(negedge clk);
            if (k == 5) begin
                chk("wr_ready_busy", wr_wide_ready[0], 0);
                chk("wr_last_stalled", wr_narrow_last[0], 1);
            end
            step();
        end
        wr_narrow_ready[0] = 1'b1;
        push_wr(0, c_w2);
        wr_wide_v[0]    = 1'b1;
        wr_wide_data[0] = c_w2;
        @(negedge clk);
        chk("wr_ready_on_last", wr_wide_ready[0], 1);
        chk("wr_last_beat4", wr_narrow_last[0], 1);
        step();
        wr_wide_v[0] = 1'b0;
        @(negedge clk);
        chk("wr_no_bubble", wr_narrow_v[0], 1);
        chk("wr_no_bubble_data", wr_narrow_data[0], c_w2[31:0]);
        step();
        for (int k = 1; k < 7; k++) begin
            wr_narrow_ready[0] = (k % 2 == 0);
            step();
        end
        wr_narrow_ready[0] = 1'b1;
        wr_word(1, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        drain();

        // Back-pressure on the read wide side
        rd_wide_ready[0] = 1'b0;
        rd_word(0, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
        rd_q0.push_back(128'h04040404_03030303_02020202_01010101);
        rd_narrow_v[0]    = 1'b1;
        rd_narrow_data[0] = 32'h01010101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rd_ready_low", rd_narrow_ready[0], 0);
            chk("bp_rd_valid_held", rd_wide_v[0], 1);
            chk("bp_rd_data_held", rd_wide_data[0], 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
            step();
        end
        chk("bp_ch1_idle", rd_wide_v[1], 0);
        rd_wide_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", rd_narrow_ready[0], 1);
        step();
        rd_beat(0, 32'h02020202);
        rd_beat(0, 32'h03030303);
        rd_beat(0, 32'h04040404);
        rd_narrow_v[0] = 1'b0;
        drain();

        // Reset in the middle of a read word and a write word
        rd_beat(0, 32'hBAD00000);
        rd_beat(0, 32'hBAD00001);
        rd_narrow_v[0] = 1'b0;
        wr_q0.push_back({1'b0, 32'h5A5A0000});
        wr_wide_v[0]    = 1'b1;
        wr_wide_data[0] = 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000;
        step();
        wr_wide_v[0] = 1'b0;
        step();
        wr_narrow_ready[0] = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("mid_reset_rd_v", rd_wide_v, 2'b00);
        chk("mid_reset_wr_v", wr_narrow_v, 2'b00);
        chk("mid_reset_wr_last", wr_narrow_last, 2'b00);
        chk("mid_reset_wr_data", wr_narrow_data[0], 0);
        chk("mid_reset_wr_ready", wr_wide_ready, 2'b11);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        wr_narrow_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_rd_quiet", rd_wide_v, 2'b00);
            chk("post_reset_wr_quiet", wr_narrow_v, 2'b00);
            step();
        end
        rd_word(0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
        drain();

`ifdef BP_AXI_DMA_GEARBOX_COUNTERS_EN
        // Counter run on channel 1 only, both directions concurrently
        @(posedge clk);
        #1 reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        step();
        fork
            begin
                for (int i = 0; i < 1000; i++)
                    rd_word(1, {$urandom, $urandom, $urandom, $urandom});
            end
            begin
                for (int j = 0; j < 1000; j++)
                    wr_word(1, {$urandom, $urandom, $urandom, $urandom});
            end
        join
        drain();
        repeat (2) step();
        chk("rd_words_ch1", rd_words[1], 1000);
        chk("wr_words_ch1", wr_words[1], 1000);
        chk("rd_words_ch0", rd_words[0], 0);
        chk("wr_words_ch0", wr_words[0], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
